// File: rtl/pixel_scheduler.sv
// pixel_scheduler: rasters one frame through the pixel mapper and hands
// each mapped pixel to a round-robin selected iteration engine.
module pixel_scheduler #(
    parameter int WORD_LENGTH   = 32,
    parameter int SCREEN_WIDTH  = 960,
    parameter int SCREEN_HEIGHT = 720,
    parameter int NUM_ENGINES   = 4,
    parameter int MAP_LATENCY   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [31:0]            zoom_in,
    input  logic [WORD_LENGTH-1:0] real_center_in,
    input  logic [WORD_LENGTH-1:0] imag_center_in,
    output logic [10:0]            map_x,
    output logic [10:0]            map_y,
    output logic [31:0]            map_zoom,
    output logic [WORD_LENGTH-1:0] map_real_center,
    output logic [WORD_LENGTH-1:0] map_imag_center,
    input  logic [WORD_LENGTH-1:0] map_real,
    input  logic [WORD_LENGTH-1:0] map_imag,
    input  logic [NUM_ENGINES-1:0] eng_ready,
    output logic [NUM_ENGINES-1:0] eng_valid,
    output logic [10:0]            eng_x,
    output logic [10:0]            eng_y,
    output logic [WORD_LENGTH-1:0] eng_c_re,
    output logic [WORD_LENGTH-1:0] eng_c_im,
    output logic                   busy,
    output logic                   frame_done
);
    localparam int PW = $clog2(NUM_ENGINES);
    localparam int CW = $clog2(MAP_LATENCY + 1);
    localparam logic [10:0] X_LAST = 11'(SCREEN_WIDTH - 1);
    localparam logic [10:0] Y_LAST = 11'(SCREEN_HEIGHT - 1);
    localparam logic [PW:0] N_ENG = (PW + 1)'(NUM_ENGINES);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                 r_state;
    state_t                 w_state_nx;
    logic [PW-1:0]          r_rr_ptr;
    logic [NUM_ENGINES-1:0] r_reserved;
    logic [NUM_ENGINES-1:0] r_vld_d1;
    logic [NUM_ENGINES-1:0] r_tok_gnt [MAP_LATENCY];
    logic [10:0]            r_tok_x   [MAP_LATENCY];
    logic [10:0]            r_tok_y   [MAP_LATENCY];
    logic [CW-1:0]          r_drain_cnt;

    logic [NUM_ENGINES-1:0] w_elig;
    logic [NUM_ENGINES-1:0] w_grant;
    logic [PW-1:0]          w_gidx;
    logic [PW-1:0]          w_rr_nx;
    logic [PW:0]            w_idx;
    logic [PW:0]            w_rr_inc;
    logic                   w_issue;
    logic                   w_last;
    logic                   w_drained;

    // Descending scan so the closest eligible index after rr_ptr wins
    always_comb begin
        w_elig = eng_ready & ~r_reserved;
        w_gidx = '0;
        w_idx  = '0;
        for (int k = NUM_ENGINES - 1; k >= 0; k--) begin
            w_idx = {1'b0, r_rr_ptr} + (PW + 1)'(k);
            if (w_idx >= N_ENG) begin
                w_idx = w_idx - N_ENG;
            end
            if (w_elig[w_idx[PW-1:0]]) begin
                w_gidx = w_idx[PW-1:0];
            end
        end
        w_issue  = (r_state == RUN) && (|w_elig);
        w_grant  = w_issue ? (NUM_ENGINES'(1) << w_gidx) : '0;
        w_rr_inc = {1'b0, w_gidx} + 1'b1;
        w_rr_nx  = (w_rr_inc == N_ENG) ? '0 : w_rr_inc[PW-1:0];
        w_last   = (map_x == X_LAST) && (map_y == Y_LAST);
        w_drained = (r_drain_cnt == CW'(MAP_LATENCY));
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            IDLE:    if (start) w_state_nx = RUN;
            RUN:     if (w_issue && w_last) w_state_nx = DRAIN;
            DRAIN:   if (w_drained) w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_rr_ptr        <= '0;
            r_reserved      <= '0;
            r_vld_d1        <= '0;
            r_drain_cnt     <= '0;
            map_x           <= '0;
            map_y           <= '0;
            map_zoom        <= '0;
            map_real_center <= '0;
            map_imag_center <= '0;
            eng_valid       <= '0;
            eng_x           <= '0;
            eng_y           <= '0;
            eng_c_re        <= '0;
            eng_c_im        <= '0;
            busy            <= 1'b0;
            frame_done      <= 1'b0;
            for (int i = 0; i < MAP_LATENCY; i++) begin
                r_tok_gnt[i] <= '0;
                r_tok_x[i]   <= '0;
                r_tok_y[i]   <= '0;
            end
        end else begin
            r_state    <= w_state_nx;
            frame_done <= 1'b0;
            if (r_state == IDLE && start) begin
                map_zoom        <= zoom_in;
                map_real_center <= real_center_in;
                map_imag_center <= imag_center_in;
                map_x           <= '0;
                map_y           <= '0;
                busy            <= 1'b1;
            end
            if (w_issue) begin
                r_rr_ptr <= w_rr_nx;
                if (map_x == X_LAST) begin
                    map_x <= '0;
                    map_y <= (map_y == Y_LAST) ? '0 : map_y + 11'd1;
                end else begin
                    map_x <= map_x + 11'd1;
                end
            end
            if (r_state == DRAIN) begin
                if (w_drained) begin
                    r_drain_cnt <= '0;
                    frame_done  <= 1'b1;
                    busy        <= 1'b0;
                end else begin
                    r_drain_cnt <= r_drain_cnt + 1'b1;
                end
            end
            // Hold an engine off until its registered ready has dropped
            r_reserved   <= (r_reserved & ~r_vld_d1) | w_grant;
            r_vld_d1     <= eng_valid;
            r_tok_gnt[0] <= w_grant;
            r_tok_x[0]   <= map_x;
            r_tok_y[0]   <= map_y;
            for (int i = 1; i < MAP_LATENCY; i++) begin
                r_tok_gnt[i] <= r_tok_gnt[i-1];
                r_tok_x[i]   <= r_tok_x[i-1];
                r_tok_y[i]   <= r_tok_y[i-1];
            end
            eng_valid <= r_tok_gnt[MAP_LATENCY-1];
            if (|r_tok_gnt[MAP_LATENCY-1]) begin
                eng_x    <= r_tok_x[MAP_LATENCY-1];
                eng_y    <= r_tok_y[MAP_LATENCY-1];
                eng_c_re <= map_real;
                eng_c_im <= map_imag;
            end
        end
    end
endmodule

// File: tb/tb_pixel_scheduler.sv
// tb_pixel_scheduler: directed checks of raster order, round-robin dispatch,
// stalls, config latching, abort and start-while-busy.
module tb_pixel_scheduler;
    localparam int WL = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          b_start = 1'b0;
    logic [31:0]   zoom_in = '0;
    logic [WL-1:0] real_center_in = '0;
    logic [WL-1:0] imag_center_in = '0;
    logic [10:0]   map_x, map_y, eng_x, eng_y;
    logic [31:0]   map_zoom;
    logic [WL-1:0] map_real_center, map_imag_center, eng_c_re, eng_c_im;
    logic [WL-1:0] map_real, map_imag, m1_re, m1_im;
    logic [1:0]    eng_ready = '0;
    logic [1:0]    eng_valid;
    logic          busy, frame_done;

    logic [10:0]   b_map_x, b_map_y, b_eng_x, b_eng_y;
    logic [31:0]   b_map_zoom;
    logic [WL-1:0] b_map_rc, b_map_ic, b_c_re, b_c_im;
    logic [WL-1:0] b_map_real, b_map_imag;
    logic [7:0]    b_ready = '0;
    logic [7:0]    b_valid;
    logic          b_busy, b_done;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int a_eng[$], a_x[$], a_y[$], a_cyc[$], a_done[$];
    logic [31:0] a_re[$], a_im[$];
    int b_eng[$], b_x[$], b_y[$], b_cyc[$], b_dn[$];

    pixel_scheduler #(
        .WORD_LENGTH(WL), .SCREEN_WIDTH(4), .SCREEN_HEIGHT(2),
        .NUM_ENGINES(2), .MAP_LATENCY(2)
    ) u_a (
        .clk(clk), .rst(rst), .start(start), .zoom_in(zoom_in),
        .real_center_in(real_center_in), .imag_center_in(imag_center_in),
        .map_x(map_x), .map_y(map_y), .map_zoom(map_zoom),
        .map_real_center(map_real_center), .map_imag_center(map_imag_center),
        .map_real(map_real), .map_imag(map_imag),
        .eng_ready(eng_ready), .eng_valid(eng_valid),
        .eng_x(eng_x), .eng_y(eng_y), .eng_c_re(eng_c_re), .eng_c_im(eng_c_im),
        .busy(busy), .frame_done(frame_done)
    );

    pixel_scheduler #(
        .WORD_LENGTH(WL), .SCREEN_WIDTH(4), .SCREEN_HEIGHT(4),
        .NUM_ENGINES(8), .MAP_LATENCY(2)
    ) u_b (
        .clk(clk), .rst(rst), .start(b_start), .zoom_in(zoom_in),
        .real_center_in(real_center_in), .imag_center_in(imag_center_in),
        .map_x(b_map_x), .map_y(b_map_y), .map_zoom(b_map_zoom),
        .map_real_center(b_map_rc), .map_imag_center(b_map_ic),
        .map_real(b_map_real), .map_imag(b_map_imag),
        .eng_ready(b_ready), .eng_valid(b_valid),
        .eng_x(b_eng_x), .eng_y(b_eng_y), .eng_c_re(b_c_re), .eng_c_im(b_c_im),
        .busy(b_busy), .frame_done(b_done)
    );

    // Two-cycle mapper stand-in: c = centre + (coord << zoom)
    always @(posedge clk) begin
        m1_re      <= map_real_center + ({21'd0, map_x} << map_zoom[4:0]);
        m1_im      <= map_imag_center + ({21'd0, map_y} << map_zoom[4:0]);
        map_real   <= m1_re;
        map_imag   <= m1_im;
        b_map_real <= {21'd0, b_map_x};
        b_map_imag <= {21'd0, b_map_y};
        cyc        <= cyc + 1;
    end

    function automatic int oh_idx(input logic [7:0] v);
        int r = -1;
        int n = 0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                r = i;
                n++;
            end
        end
        return (n == 1) ? r : -1;
    endfunction

    always @(negedge clk) begin
        if (eng_valid != '0) begin
            a_eng.push_back(oh_idx({6'd0, eng_valid}));
            a_x.push_back(int'(eng_x));
            a_y.push_back(int'(eng_y));
            a_re.push_back(eng_c_re);
            a_im.push_back(eng_c_im);
            a_cyc.push_back(cyc);
        end
        if (frame_done) a_done.push_back(cyc);
        if (b_valid != '0) begin
            b_eng.push_back(oh_idx(b_valid));
            b_x.push_back(int'(b_eng_x));
            b_y.push_back(int'(b_eng_y));
            b_cyc.push_back(cyc);
        end
        if (b_done) b_dn.push_back(cyc);
    end

    task automatic clr_q;
        a_eng.delete(); a_x.delete(); a_y.delete(); a_cyc.delete();
        a_done.delete(); a_re.delete(); a_im.delete();
        b_eng.delete(); b_x.delete(); b_y.delete(); b_cyc.delete();
        b_dn.delete();
    endtask

    task automatic do_reset;
        rst = 1'b1;
        start = 1'b0;
        b_start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        clr_q;
    endtask

    task automatic pulse_start(output int s);
        start = 1'b1;
        @(posedge clk);
        #1 s = cyc;
        start = 1'b0;
    endtask

    task automatic test_reset;
        zoom_in = 32'd5;
        real_center_in = 32'd123;
        imag_center_in = 32'd9;
        eng_ready = 2'b11;
        b_ready = 8'hFF;
        rst = 1'b1;
        start = 1'b1;
        b_start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        b_start = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        clr_q;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        total++; if (eng_valid !== 2'b00) begin bad++; $display("FAIL reset_valid got=%0b exp=0", eng_valid); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", frame_done); end
        total++; if (map_x !== 11'd0 || map_y !== 11'd0) begin bad++; $display("FAIL reset_xy got=%0d,%0d exp=0,0", map_x, map_y); end
        total++; if (map_zoom !== 32'd0) begin bad++; $display("FAIL reset_zoom got=%0d exp=0", map_zoom); end
        total++; if (map_real_center !== '0 || map_imag_center !== '0) begin bad++; $display("FAIL reset_center got=%0d,%0d exp=0,0", map_real_center, map_imag_center); end
        total++; if (eng_x !== 11'd0 || eng_c_re !== '0) begin bad++; $display("FAIL reset_engbus got=%0d,%0d exp=0,0", eng_x, eng_c_re); end
        total++; if (b_busy !== 1'b0 || b_valid !== 8'd0) begin bad++; $display("FAIL reset_b got=%0b,%0h exp=0,0", b_busy, b_valid); end
        repeat (10) @(posedge clk);
        #1;
        total++; if (a_eng.size() != 0 || busy !== 1'b0) begin bad++; $display("FAIL rst_start_idle got=%0d,%0b exp=0,0", a_eng.size(), busy); end
    endtask

    task automatic test_raster;
        int s;
        int n;
        int offs[8] = '{3, 4, 8, 9, 13, 14, 18, 19};
        do_reset;
        eng_ready = 2'b11;
        zoom_in = '0; real_center_in = '0; imag_center_in = '0;
        pulse_start(s);
        for (int k = 0; k < 100 && a_done.size() == 0; k++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        total++; if (a_done.size() != 1) begin bad++; $display("FAIL raster_done_cnt got=%0d exp=1", a_done.size()); end
        total++; if (a_eng.size() != 8) begin bad++; $display("FAIL raster_count got=%0d exp=8", a_eng.size()); end
        n = (a_eng.size() < 8) ? a_eng.size() : 8;
        for (int k = 0; k < n; k++) begin
            total++;
            if (a_eng[k] != k % 2 || a_x[k] != k % 4 || a_y[k] != k / 4) begin
                bad++;
                $display("FAIL raster_pix%0d got=e%0d(%0d,%0d) exp=e%0d(%0d,%0d)", k, a_eng[k], a_x[k], a_y[k], k % 2, k % 4, k / 4);
            end
            total++;
            if (a_cyc[k] != s + offs[k]) begin
                bad++;
                $display("FAIL raster_time%0d got=%0d exp=%0d", k, a_cyc[k] - s, offs[k]);
            end
        end
        total++; if (a_done.size() == 0 || a_done[0] != s + 20) begin bad++; $display("FAIL raster_done_time exp=%0d", 20); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL raster_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_stall;
        int s;
        int n;
        do_reset;
        eng_ready = 2'b00;
        pulse_start(s);
        repeat (10) @(posedge clk);
        #1;
        total++; if (a_eng.size() != 0) begin bad++; $display("FAIL stall_dispatch got=%0d exp=0", a_eng.size()); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL stall_busy got=%0b exp=1", busy); end
        eng_ready = 2'b01;
        for (int k = 0; k < 200 && a_done.size() == 0; k++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        total++; if (a_eng.size() != 8) begin bad++; $display("FAIL stall_count got=%0d exp=8", a_eng.size()); end
        n = (a_eng.size() < 8) ? a_eng.size() : 8;
        for (int k = 0; k < n; k++) begin
            total++;
            if (a_eng[k] != 0 || a_x[k] != k % 4 || a_y[k] != k / 4 || a_cyc[k] != s + 13 + 5 * k) begin
                bad++;
                $display("FAIL stall_pix%0d got=e%0d(%0d,%0d)@%0d exp=e0(%0d,%0d)@%0d", k, a_eng[k], a_x[k], a_y[k], a_cyc[k] - s, k % 4, k / 4, 13 + 5 * k);
            end
        end
        total++; if (a_done.size() != 1 || a_done[0] != s + 49) begin bad++; $display("FAIL stall_done got=%0d exp=1@49", a_done.size()); end
    endtask

    task automatic test_config;
        int s;
        int n;
        logic [31:0] er, ei;
        do_reset;
        eng_ready = 2'b11;
        zoom_in = 32'd0;
        real_center_in = 32'd100;
        imag_center_in = 32'(-50);
        pulse_start(s);
        repeat (2) @(posedge clk);
        #1;
        zoom_in = 32'd3;
        real_center_in = 32'd7777;
        imag_center_in = 32'd1;
        @(posedge clk);
        #1;
        total++; if (map_zoom !== 32'd0) begin bad++; $display("FAIL cfg_zoom_held got=%0d exp=0", map_zoom); end
        total++; if (map_real_center !== 32'd100 || map_imag_center !== 32'(-50)) begin bad++; $display("FAIL cfg_center_held got=%0d,%0d exp=100,-50", $signed(map_real_center), $signed(map_imag_center)); end
        for (int k = 0; k < 100 && a_done.size() == 0; k++) @(posedge clk);
        #1;
        n = (a_re.size() < 8) ? a_re.size() : 8;
        total++; if (n != 8) begin bad++; $display("FAIL cfg_count1 got=%0d exp=8", n); end
        for (int k = 0; k < n; k++) begin
            er = 32'(100 + k % 4);
            ei = 32'(-50 + k / 4);
            total++;
            if (a_re[k] !== er || a_im[k] !== ei) begin
                bad++;
                $display("FAIL cfg_c1_%0d got=%0d,%0d exp=%0d,%0d", k, $signed(a_re[k]), $signed(a_im[k]), $signed(er), $signed(ei));
            end
        end
        clr_q;
        pulse_start(s);
        total++; if (map_zoom !== 32'd3 || map_real_center !== 32'd7777) begin bad++; $display("FAIL cfg_relatch got=%0d,%0d exp=3,7777", map_zoom, map_real_center); end
        for (int k = 0; k < 100 && a_done.size() == 0; k++) @(posedge clk);
        #1;
        n = (a_re.size() < 8) ? a_re.size() : 8;
        total++; if (n != 8) begin bad++; $display("FAIL cfg_count2 got=%0d exp=8", n); end
        for (int k = 0; k < n; k++) begin
            er = 32'(7777 + ((k % 4) << 3));
            ei = 32'(1 + ((k / 4) << 3));
            total++;
            if (a_re[k] !== er || a_im[k] !== ei) begin
                bad++;
                $display("FAIL cfg_c2_%0d got=%0d,%0d exp=%0d,%0d", k, a_re[k], a_im[k], er, ei);
            end
        end
    endtask

    task automatic test_abort;
        int s;
        do_reset;
        eng_ready = 2'b11;
        zoom_in = '0; real_center_in = '0; imag_center_in = '0;
        pulse_start(s);
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        total++; if (eng_valid !== 2'b00 || busy !== 1'b0) begin bad++; $display("FAIL abort_outputs got=%0b,%0b exp=0,0", eng_valid, busy); end
        repeat (15) @(posedge clk);
        #1;
        total++; if (a_eng.size() != 3) begin bad++; $display("FAIL abort_dispatches got=%0d exp=3", a_eng.size()); end
        total++; if (a_done.size() != 0) begin bad++; $display("FAIL abort_done got=%0d exp=0", a_done.size()); end
        clr_q;
        pulse_start(s);
        for (int k = 0; k < 100 && a_done.size() == 0; k++) @(posedge clk);
        #1;
        total++; if (a_eng.size() != 8) begin bad++; $display("FAIL abort_restart_count got=%0d exp=8", a_eng.size()); end
        total++; if (a_eng.size() == 0 || a_x[0] != 0 || a_y[0] != 0 || a_eng[0] != 0) begin bad++; $display("FAIL abort_restart_first exp=e0(0,0)"); end
    endtask

    task automatic test_start_busy;
        int s;
        do_reset;
        eng_ready = 2'b11;
        pulse_start(s);
        repeat (4) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (12) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        total++; if (a_eng.size() != 8) begin bad++; $display("FAIL sbusy_count got=%0d exp=8", a_eng.size()); end
        total++; if (a_done.size() != 1 || a_done[0] != s + 20) begin bad++; $display("FAIL sbusy_done got=%0d exp=1@20", a_done.size()); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL sbusy_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_rr8;
        int s;
        int n;
        do_reset;
        b_ready = 8'hFF;
        b_start = 1'b1;
        @(posedge clk);
        #1 s = cyc;
        b_start = 1'b0;
        for (int k = 0; k < 100 && b_dn.size() == 0; k++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        total++; if (b_eng.size() != 16) begin bad++; $display("FAIL rr8_count got=%0d exp=16", b_eng.size()); end
        n = (b_eng.size() < 16) ? b_eng.size() : 16;
        for (int k = 0; k < n; k++) begin
            total++;
            if (b_eng[k] != k % 8 || b_x[k] != k % 4 || b_y[k] != k / 4 || b_cyc[k] != s + 3 + k) begin
                bad++;
                $display("FAIL rr8_pix%0d got=e%0d(%0d,%0d)@%0d exp=e%0d(%0d,%0d)@%0d", k, b_eng[k], b_x[k], b_y[k], b_cyc[k] - s, k % 8, k % 4, k / 4, 3 + k);
            end
        end
        total++; if (b_dn.size() != 1 || b_dn[0] != s + 19) begin bad++; $display("FAIL rr8_done got=%0d exp=1@19", b_dn.size()); end
        total++; if (b_busy !== 1'b0) begin bad++; $display("FAIL rr8_busy got=%0b exp=0", b_busy); end
    endtask

    initial begin
        test_reset;
        test_raster;
        test_stall;
        test_config;
        test_abort;
        test_start_busy;
        test_rr8;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pixel_scheduler.md
Name: pixel_scheduler

Overview:
- Frame-level controller for the multi-engine Mandelbrot datapath.
- Rasters pixel coordinates across the screen and drives the pixel-to-complex mapper. The mapper takes x, y, zoom and centre and returns c after 2 cycles.
- Dispatches each mapped (x, y, c) to one of NUM_ENGINES iteration engines using round-robin arbitration over ready engines.
- Latches view configuration (zoom, centre) at frame start so a whole frame renders with one consistent view.

Parameters:
- WORD_LENGTH, 32, width of signed fixed-point complex values.
- SCREEN_WIDTH, 960, pixels per line.
- SCREEN_HEIGHT, 720, lines per frame.
- NUM_ENGINES, 4, number of iteration engines served (2..16).
- MAP_LATENCY, 2, mapper latency in cycles; fixed by the mapper design.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: begin a frame
- zoom_in  in  32  zoom shift for the next frame
- real_center_in  in  WORD_LENGTH  signed centre (real)
- imag_center_in  in  WORD_LENGTH  signed centre (imag)
- map_x  out  11  x to mapper
- map_y  out  11  y to mapper
- map_zoom  out  32  latched zoom to mapper
- map_real_center  out  WORD_LENGTH  latched centre to mapper
- map_imag_center  out  WORD_LENGTH  latched centre to mapper
- map_real  in  WORD_LENGTH  mapper real result
- map_imag  in  WORD_LENGTH  mapper imag result
- eng_ready  in  NUM_ENGINES  per-engine: can accept a pixel
- eng_valid  out  NUM_ENGINES  one-hot dispatch strobe
- eng_x  out  11  dispatched pixel x (shared bus)
- eng_y  out  11  dispatched pixel y (shared bus)
- eng_c_re  out  WORD_LENGTH  dispatched c real (shared bus)
- eng_c_im  out  WORD_LENGTH  dispatched c imag (shared bus)
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after the last dispatch

Behaviour:
- Reset
  - All outputs are 0; FSM goes to IDLE.
  - Reserved mask and pipeline tokens are cleared; round-robin pointer goes to 0.
  - Reset mid-frame aborts the frame: no eng_valid and no frame_done follow.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: on start, latch zoom_in and both centres into the map_* outputs, set x=y=0, busy=1, go to RUN.
  - RUN: start is ignored. Issue at most one pixel per cycle.
  - DRAIN: entered the cycle after pixel (SCREEN_WIDTH-1, SCREEN_HEIGHT-1) issues. Waits MAP_LATENCY cycles until the pipeline is empty, pulses frame_done for 1 cycle, then clears busy in the same cycle and returns to IDLE.
- Issue (RUN)
  - An engine i is eligible when eng_ready[i]=1 and reserved[i]=0.
  - If any engine is eligible, grant the first eligible index at or after rr_ptr, searching cyclically. Then set rr_ptr to grant+1 mod NUM_ENGINES.
  - Current map_x/map_y are presented to the mapper in the issue cycle.
  - The raster advances next cycle: x+1; at x=SCREEN_WIDTH-1, x wraps to 0 and y increments.
  - If no engine is eligible, x and y hold; this is a stall.
- Pipeline
  - The grant (one-hot) plus x and y travel through a MAP_LATENCY-deep token shift register.
  - When a token emerges, eng_valid is set to the carried one-hot. eng_x/eng_y come from the token; eng_c_re/eng_c_im come from map_real/map_imag.
  - eng_valid is registered, so it is a 1-cycle pulse per pixel.
  - Token pipeline shifts every cycle, stall or not; mapper inputs are sampled only on issue cycles.
  - Issue-to-dispatch latency: eng_valid is high in cycle t+MAP_LATENCY+1 for issue cycle t.
- Reservation
  - reserved[i] is set in the cycle after grant and cleared 2 cycles after eng_valid[i] pulses.
  - This covers the engine's registered ready drop and prevents double-grant.
  - Engine contract: eng_ready[i] is low no later than 1 cycle after eng_valid[i].
- Boundaries
  - Simultaneous start and rst: rst wins.
  - Config inputs changing mid-frame do not affect map_* outputs.
  - All engines not ready: indefinite stall, no dispatch, busy held.
  - Throughput is 1 pixel/cycle when at least MAP_LATENCY+3 engines rotate.
  - Every pixel dispatches exactly once, in raster order.

Test Plan:
- Reset, then start with SCREEN_WIDTH=4, SCREEN_HEIGHT=2, NUM_ENGINES=2, both engines always ready after the reservation drop -> 8 eng_valid pulses, (x,y) in order (0,0)..(3,1), alternating engines 0,1,0,1…; frame_done 1 cycle after the 8th pulse; busy low afterwards.
- Same parameters, eng_ready=2'b00 for 10 cycles after start, then 2'b01 -> no eng_valid during the stall; all 8 pixels go to engine 0, spaced by the reservation window; no pixel skipped or duplicated.
- Change zoom_in from 0 to 3 and real_center_in mid-frame -> map_zoom stays 0 and centre is unchanged until the next start; eng_c_re equals the mapper output for the latched values.
- Assert rst after 3 dispatches -> eng_valid=0, busy=0, no frame_done; a following start restarts at (0,0).
- Pulse start while busy -> ignored: exactly 8 dispatches and one frame_done.
- NUM_ENGINES=8, all ready -> after the first dispatch, one eng_valid per cycle; no engine is granted again while reserved; round-robin order is 0..7, then wraps.
